// File: rtl/wb_arbiter2_if.sv
// wb_arbiter2_if: bus bundle between two Wishbone masters, the arbiter and one pipelined slave
//   m_*_i  : packed per-master requests (bit / slice n belongs to master n)
//   m_*_o  : read data broadcast plus per-master ack/err/stall
//   s_*_o  : muxed request toward the slave
//   s_*_i  : slave response
//   modport slave  : arbiter view
//   modport master : view of the requesters and the slave model around the arbiter
interface wb_arbiter2_if #(
  parameter int AW = 3,
  parameter int DW = 32
);
  logic [1:0]        m_cyc_i;
  logic [1:0]        m_stb_i;
  logic [1:0]        m_we_i;
  logic [2*AW-1:0]   m_adr_i;
  logic [2*DW/8-1:0] m_sel_i;
  logic [2*DW-1:0]   m_dat_i;
  logic [DW-1:0]     m_dat_o;
  logic [1:0]        m_ack_o;
  logic [1:0]        m_err_o;
  logic [1:0]        m_stall_o;
  logic              s_cyc_o;
  logic              s_stb_o;
  logic              s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW/8-1:0]   s_sel_o;
  logic [DW-1:0]     s_dat_o;
  logic              s_ack_i;
  logic              s_err_i;
  logic              s_stall_i;
  logic [DW-1:0]     s_dat_i;
  modport slave (
    input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, s_ack_i, s_err_i, s_stall_i, s_dat_i,
    output m_dat_o, m_ack_o, m_err_o, m_stall_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );
  modport master (
    output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_sel_i, m_dat_i, s_ack_i, s_err_i, s_stall_i, s_dat_i,
    input  m_dat_o, m_ack_o, m_err_o, m_stall_o, s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_sel_o, s_dat_o
  );
endinterface

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: round-robin two-master Wishbone arbiter with bus lock and response watchdog
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset
//   bus   : wb_arbiter2_if.slave carrying both master ports and the shared slave port
module wb_arbiter2 #(
  parameter int AW = 3,
  parameter int DW = 32,
  parameter int TIMEOUT = 255
) (
  input logic         clk_i,
  input logic         rst_i,
  wb_arbiter2_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t     state_q, state_d;
  logic       grant_q, grant_d, last_q, last_d;
  logic [7:0] tmr_q, tmr_d;
  logic [1:0] req;
  logic       win, busy, acc, live, resp, to;
  always_comb begin
    req = bus.m_cyc_i & bus.m_stb_i;
    win = &req ? ~last_q : req[1];
    // dropping cyc on the granted master aborts everything combinationally
    busy = state_q != IDLE && bus.m_cyc_i[grant_q];
    acc = busy && state_q == ISSUE && !bus.s_stall_i;
    // responses count only once the strobe has been accepted
    live = acc || (busy && state_q == WAIT);
    resp = live && (bus.s_ack_i || bus.s_err_i);
    to = busy && (state_q == ISSUE || state_q == WAIT) && tmr_q == 8'(TIMEOUT) && !resp;
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    tmr_d = tmr_q;
    case (state_q)
      IDLE: if (|req) begin
        state_d = ISSUE;
        grant_d = win;
        last_d = win;
        tmr_d = '0;
      end
      ISSUE, WAIT: begin
        state_d = !busy ? IDLE : (resp || to) ? HOLD : (acc || state_q == WAIT) ? WAIT : ISSUE;
        tmr_d = tmr_q + 8'(tmr_q != 8'(TIMEOUT));
      end
      default: begin
        state_d = !busy ? IDLE : bus.m_stb_i[grant_q] ? ISSUE : HOLD;
        tmr_d = '0;
      end
    endcase
  end
  assign bus.s_cyc_o = busy;
  assign bus.s_stb_o = busy && state_q == ISSUE;
  assign bus.s_adr_o = grant_q ? bus.m_adr_i[AW +: AW] : bus.m_adr_i[0 +: AW];
  assign bus.s_sel_o = grant_q ? bus.m_sel_i[DW/8 +: DW/8] : bus.m_sel_i[0 +: DW/8];
  assign bus.s_dat_o = grant_q ? bus.m_dat_i[DW +: DW] : bus.m_dat_i[0 +: DW];
  assign bus.s_we_o = bus.m_we_i[grant_q];
  assign bus.m_dat_o = bus.s_dat_i;
  assign bus.m_ack_o = 2'(live && bus.s_ack_i) << grant_q;
  assign bus.m_err_o = 2'((live && bus.s_err_i) || to) << grant_q;
  // a timeout in ISSUE also releases the stall so the master's strobe terminates
  assign bus.m_stall_o = ~(2'(busy && state_q == ISSUE && (!bus.s_stall_i || to)) << grant_q);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q <= 1'b1;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q <= last_d;
      tmr_q <= tmr_d;
    end
  end
endmodule

// File: doc/wb_arbiter2.md
# wb_arbiter2

Two-master Wishbone arbiter that shares one pipelined Wishbone slave port, such as a generated register bank with `wb_stall_o`, between two requesters. Arbitration is round-robin, and a master keeps its grant for as long as it holds `cyc` (bus lock). One transfer is outstanding at a time, and a watchdog terminates transfers the slave never answers. It sits between the bus masters (CPU bridge, DMA or sequencer) and the register bank.

## Interface
- `AW`, default 3: address width (word address bits `[AW-1:0]`).
- `DW`, default 32: data width.
- `TIMEOUT`, default 255: cycles without slave response before the arbiter forces an error (1..255).
- `clk_i`  in  1  single clock; all logic on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `m_cyc_i`  in  2  per-master cycle; bit n belongs to master n.
- `m_stb_i`  in  2  per-master strobe.
- `m_adr_i`  in  2*AW  master n address at `[n*AW +: AW]`.
- `m_sel_i`  in  2*DW/8  byte selects, packed the same way.
- `m_we_i`  in  2  write enable.
- `m_dat_i`  in  2*DW  write data, packed.
- `m_dat_o`  out  DW  read data, `s_dat_i` broadcast to both masters.
- `m_ack_o`  out  2  acknowledge; only the granted bit may be 1.
- `m_err_o`  out  2  error (slave error or timeout); only the granted bit may be 1.
- `m_stall_o`  out  2  stall; 1 except on the granted master's accept cycle.
- `s_cyc_o`  out  1  slave cycle.
- `s_stb_o`  out  1  slave strobe.
- `s_adr_o`  out  AW  address muxed from the granted master.
- `s_sel_o`  out  DW/8  byte selects muxed from the granted master.
- `s_we_o`  out  1  write enable muxed from the granted master.
- `s_dat_o`  out  DW  write data muxed from the granted master.
- `s_ack_i`  in  1  slave acknowledge.
- `s_err_i`  in  1  slave error.
- `s_stall_i`  in  1  slave stall.
- `s_dat_i`  in  DW  slave read data.

## Operation
- Registered state: FSM {IDLE, ISSUE, WAIT, HOLD}, `grant` (1 bit), `last` (1 bit), 8-bit timer `tmr`.
- **IDLE**: `s_cyc_o=0`. A master requests when its `cyc&stb` is 1.
  - One requester: it wins.
  - Both request: the master `!last` wins.
  - On a win: `grant<=winner`, `last<=winner`, `tmr<=0`, go to ISSUE.
- **ISSUE**: `s_cyc_o=1`, `s_stb_o=1`; address, select, write enable and data are muxed from `grant`.
  - `s_stall_i=0`: the transfer is accepted and `m_stall_o[grant]=0` this cycle.
    - If `s_ack_i|s_err_i` in the same cycle, forward it and go to HOLD.
    - Otherwise go to WAIT.
- **WAIT**: `s_cyc_o=1`, `s_stb_o=0`. When `s_ack_i|s_err_i` arrives, forward it combinationally to `grant` and go to HOLD.
- **HOLD**: `s_cyc_o=1`, `s_stb_o=0`, `tmr<=0`.
  - `m_stb_i[grant]=1`: go to ISSUE next cycle.
  - `m_cyc_i[grant]=0`: go to IDLE.
- **Timer**: `tmr` increments each cycle in ISSUE/WAIT, saturating at `TIMEOUT`.
  - At `tmr==TIMEOUT` with no response: `m_err_o[grant]=1` for one cycle and go to HOLD.
  - If the timeout hits in ISSUE, `m_stall_o[grant]=0` in that cycle, so the master's strobe is terminated.
- **Master abort**: `m_cyc_i[grant]=0` in ISSUE/WAIT/HOLD forces `s_cyc_o=0` and `s_stb_o=0` combinationally that cycle; next state is IDLE.
- **Ignored responses**:
  - Slave responses in IDLE or HOLD are ignored and never forwarded (late ack after timeout or abort).
  - The ungranted master never sees ack/err.
- Simultaneous `s_ack_i` and `s_err_i`: forward both.

## Timing
- Reset values:
  - state IDLE, `grant=0`, `last=1` (master 0 wins the first tie), `tmr=0`.
  - `s_cyc_o=0`, `s_stb_o=0`, `m_ack_o=00`, `m_err_o=00`, `m_stall_o=11`.
  - Muxed slave outputs follow `grant=0`.
- Reset mid-transfer returns to IDLE on the next edge; no ack/err is produced.
- Arbitration latency: a request in cycle t (IDLE) gives `s_stb_o=1` in t+1.
- Ack latency: `m_ack_o` is in the same cycle as `s_ack_i`.
- Back-to-back under lock: ack in cycle t (HOLD at t+1), master stb at t+1 gives ISSUE at t+2. Minimum 3 cycles per transfer with a 1-cycle slave.
- A locked master keeps the grant indefinitely; fairness applies only when `cyc` drops.
- Timeout: an unanswered transfer entering ISSUE in cycle t errors in cycle t+TIMEOUT.

## Test plan
- Single read, master 0, address 1; slave stalls 2 cycles then acks with `0xDEADBEEF` -> `m_stall_o[0]=0` and `m_ack_o=01` in the same cycle, `m_dat_o=0xDEADBEEF`, `s_cyc_o` drops the cycle after master 0 drops cyc.
- Both masters request from reset, each doing one write and dropping cyc -> grant order 0, 1, 0, 1 over 4 transfers; `m_ack_o` is never 11; master 1 stays stalled while master 0 is locked.
- Master 1 locked for 3 back-to-back writes `0x1`, `0x2`, `0x3` to addresses 0, 1, 2 while master 0 requests -> slave sees the three writes in order; master 0's first `s_stb_o` appears only after master 1's cyc drops.
- Slave never responds, `TIMEOUT=8` -> `m_err_o[grant]=1` exactly 8 cycles after `s_stb_o` rises; a late `s_ack_i` 2 cycles later produces no `m_ack_o`.
- Master 0 drops cyc in WAIT -> `s_cyc_o=0` in the same cycle, FSM reaches IDLE, and a pending master 1 gets `s_stb_o` on the following cycle.
- `rst_i` pulsed during WAIT -> all outputs return to their reset values the cycle after; no ack/err is emitted; master 0 wins the next tie.
